can_bit_destuffer: RTL and testbench



---
 rtl/can_pkg.sv | 15 +
 rtl/can_idle_detector.sv | 42 ++++
 rtl/can_bit_destuffer.sv | 156 +++++++++++++++
 tb/tb_can_bit_destuffer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared types and bus-level constants for the CAN
// receive front end (bit destuffer and helpers).
package can_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ACTIVE,
    ERROR
  } destuff_state_e;

  localparam logic CAN_RECESSIVE = 1'b1;
  localparam logic CAN_DOMINANT  = 1'b0;

endpackage

// File: rtl/can_idle_detector.sv
// Counts consecutive recessive samples; idle_hit
// fires on the sample that completes IDLE_BITS.
module can_idle_detector
  import can_pkg::*;
#(
  parameter int IDLE_BITS = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic data,
  input  logic clear,
  output logic idle_hit
);

  localparam int CW = $clog2(IDLE_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(IDLE_BITS - 1);
  localparam logic [CW-1:0] TOP  = CW'(IDLE_BITS);

  logic [CW-1:0] idle_cnt;
  logic          rec;

  assign rec = sample_en && (data == CAN_RECESSIVE);

  assign idle_hit = rec && !clear
                 && (idle_cnt >= LAST);

  // saturating run counter of recessive samples
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (clear) begin
      idle_cnt <= '0;
    end else if (sample_en) begin
      if (!rec)
        idle_cnt <= '0;
      else if (idle_cnt != TOP)
        idle_cnt <= idle_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/can_bit_destuffer.sv
// CAN receive destuffer: SOF detect, stuff removal/check.
// Optional counters: define CAN_DESTUFF_STATS_EN.
module can_bit_destuffer
  import can_pkg::*;
#(
  parameter int IDLE_BITS = 11,
  parameter int STUFF_LEN = 5,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data,
  input  logic             sample_en,
  input  logic             bit_stuffing_EN,
  input  logic             frame_end,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             sof,
  output logic             stuff_err,
  output logic             bus_idle,
  output logic [CNT_W-1:0] stuff_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int RW = $clog2(STUFF_LEN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STUFF_LEN);

  destuff_state_e state_q, state_d;
  logic [RW-1:0]  run_len_q, run_len_d;
  logic           run_val_q, run_val_d;
  logic           bit_out_d, bit_valid_d;
  logic           sof_d, err_d;
  logic           stuff_hit;
  logic           idle_hit, idle_clr;

  // idle counting only runs in WAIT_IDLE and ERROR
  assign idle_clr = (state_q == IDLE)
                 || (state_q == ACTIVE);

  can_idle_detector #(
    .IDLE_BITS(IDLE_BITS)
  ) u_idle (
    .clk      (clk),
    .reset    (reset),
    .sample_en(sample_en),
    .data     (data),
    .clear    (idle_clr),
    .idle_hit (idle_hit)
  );

  // state, run tracker and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WAIT_IDLE;
      run_len_q <= '0;
      run_val_q <= CAN_RECESSIVE;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      sof       <= 1'b0;
      stuff_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_len_q <= run_len_d;
      run_val_q <= run_val_d;
      bit_out   <= bit_out_d;
      bit_valid <= bit_valid_d;
      sof       <= sof_d;
      stuff_err <= err_d;
    end
  end

  // next-state, run update and emission decode
  always_comb begin
    state_d     = state_q;
    run_len_d   = run_len_q;
    run_val_d   = run_val_q;
    bit_out_d   = 1'b0;
    bit_valid_d = 1'b0;
    sof_d       = 1'b0;
    err_d       = 1'b0;
    stuff_hit   = 1'b0;
    unique case (state_q)
      WAIT_IDLE, ERROR: begin
        if (idle_hit)
          state_d = IDLE;
      end
      IDLE: begin
        if (sample_en && data == CAN_DOMINANT) begin
          state_d     = ACTIVE;
          bit_out_d   = CAN_DOMINANT;
          bit_valid_d = 1'b1;
          sof_d       = 1'b1;
          run_val_d   = CAN_DOMINANT;
          run_len_d   = RW'(1);
        end
      end
      ACTIVE: begin
        if (sample_en) begin
          if (bit_stuffing_EN
              && run_len_q == RUN_MAX) begin
            if (data != run_val_q) begin
              stuff_hit = 1'b1;
              run_val_d = data;
              run_len_d = RW'(1);
            end else begin
              err_d = 1'b1;
            end
          end else begin
            bit_out_d   = data;
            bit_valid_d = 1'b1;
            if (data != run_val_q) begin
              run_val_d = data;
              run_len_d = RW'(1);
            end else if (run_len_q != RUN_MAX) begin
              run_len_d = run_len_q + RW'(1);
            end
          end
        end
        // a violation on the closing bit still wins
        if (err_d)
          state_d = ERROR;
        else if (frame_end)
          state_d = WAIT_IDLE;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign bus_idle = (state_q == IDLE);

`ifdef CAN_DESTUFF_STATS_EN
  logic [CNT_W-1:0] stuff_cnt_q, err_cnt_q;

  // saturating statistics, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stuff_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (stuff_hit && stuff_cnt_q != '1)
        stuff_cnt_q <= stuff_cnt_q + CNT_W'(1);
      if (err_d && err_cnt_q != '1)
        err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign stuff_cnt = stuff_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  logic stats_unused;
  assign stats_unused = stuff_hit;
  assign stuff_cnt    = '0;
  assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Directed bench for can_bit_destuffer.
// Expected counter values follow CAN_DESTUFF_STATS_EN.
module tb_can_bit_destuffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       data;
  logic       sample_en;
  logic       bit_stuffing_EN;
  logic       frame_end;
  logic       bit_out;
  logic       bit_valid;
  logic       sof;
  logic       stuff_err;
  logic       bus_idle;
  logic [7:0] stuff_cnt;
  logic [7:0] err_cnt;

  int n_run  = 0;
  int n_fail = 0;

`ifdef CAN_DESTUFF_STATS_EN
  localparam int ST = 1;
`else
  localparam int ST = 0;
`endif

  can_bit_destuffer dut (
    .clk            (clk),
    .reset          (reset),
    .data           (data),
    .sample_en      (sample_en),
    .bit_stuffing_EN(bit_stuffing_EN),
    .frame_end      (frame_end),
    .bit_out        (bit_out),
    .bit_valid      (bit_valid),
    .sof            (sof),
    .stuff_err      (stuff_err),
    .bus_idle       (bus_idle),
    .stuff_cnt      (stuff_cnt),
    .err_cnt        (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // one sampled bit; returns at the negedge after
  // the capturing posedge
  task automatic send(input logic b,
                      input logic fe = 1'b0);
    @(negedge clk);
    data      = b;
    sample_en = 1'b1;
    frame_end = fe;
    @(negedge clk);
    sample_en = 1'b0;
    frame_end = 1'b0;
    data      = 1'b1;
  endtask

  task automatic recs(input int n);
    repeat (n) send(1'b1);
  endtask

  task automatic chk_bit(input string tag,
                         input logic v,
                         input logic b);
    chk({tag, "_valid"}, 32'(bit_valid), 32'(v));
    if (v)
      chk({tag, "_bit"}, 32'(bit_out), 32'(b));
    chk({tag, "_err"}, 32'(stuff_err), 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    data            = 1'b1;
    sample_en       = 1'b1;
    bit_stuffing_EN = 1'b1;
    frame_end       = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bit_valid), 0);
    chk("rst_sof",   32'(sof), 0);
    chk("rst_err",   32'(stuff_err), 0);
    chk("rst_idle",  32'(bus_idle), 0);
    chk("rst_scnt",  32'(stuff_cnt), 0);
    chk("rst_ecnt",  32'(err_cnt), 0);
    reset     = 1'b0;
    sample_en = 1'b0;

    // 1: idle detection and SOF
    recs(10);
    chk("t1_idle10", 32'(bus_idle), 0);
    recs(1);
    chk("t1_idle11", 32'(bus_idle), 1);
    send(1'b0);
    chk("t1_sof", 32'(sof), 1);
    chk_bit("t1_sofbit", 1'b1, 1'b0);
    chk("t1_busy", 32'(bus_idle), 0);
    @(negedge clk);
    chk("t1_strobe", 32'(bit_valid), 0);
    chk("t1_sof_off", 32'(sof), 0);

    // 2: stuff bit removed after 5 dominant
    for (int i = 0; i < 4; i++) begin
      send(1'b0);
      chk_bit("t2_d", 1'b1, 1'b0);
      chk("t2_nosof", 32'(sof), 0);
    end
    send(1'b1);
    chk_bit("t2_stuff", 1'b0, 1'b0);
    send(1'b1);
    chk_bit("t2_after", 1'b1, 1'b1);
    chk("t2_scnt", 32'(stuff_cnt), 32'(ST));
    @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    recs(10);
    chk("t2_idle10", 32'(bus_idle), 0);
    recs(1);
    chk("t2_idle11", 32'(bus_idle), 1);

    // 3: six dominant -> stuff error
    send(1'b0);
    chk("t3_sof", 32'(sof), 1);
    for (int i = 0; i < 4; i++) begin
      send(1'b0);
      chk_bit("t3_d", 1'b1, 1'b0);
    end
    send(1'b0);
    chk("t3_err", 32'(stuff_err), 1);
    chk("t3_errv", 32'(bit_valid), 0);
    send(1'b0);
    chk_bit("t3_quiet0", 1'b0, 1'b0);
    send(1'b1);
    chk_bit("t3_quiet1", 1'b0, 1'b0);
    recs(10);
    chk("t3_idle", 32'(bus_idle), 1);
    chk("t3_ecnt", 32'(err_cnt), 32'(ST));

    // 4: stuffing disabled, SOF + 7 dominant
    bit_stuffing_EN = 1'b0;
    send(1'b0);
    chk("t4_sof", 32'(sof), 1);
    chk_bit("t4_sofbit", 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      send(1'b0);
      chk_bit("t4_d", 1'b1, 1'b0);
    end
    // re-enabled mid-frame with a saturated run
    bit_stuffing_EN = 1'b1;
    send(1'b0);
    chk("t4_err", 32'(stuff_err), 1);
    chk("t4_errv", 32'(bit_valid), 0);
    recs(11);
    chk("t4_idle", 32'(bus_idle), 1);
    chk("t4_ecnt", 32'(err_cnt), 32'(2 * ST));

    // 5: frame_end with a legal bit
    send(1'b0);
    chk("t5_sof", 32'(sof), 1);
    send(1'b1);
    chk_bit("t5_b1", 1'b1, 1'b1);
    send(1'b0, 1'b1);
    chk_bit("t5_fe", 1'b1, 1'b0);
    chk("t5_fe_idle", 32'(bus_idle), 0);
    recs(10);
    chk("t5_idle10", 32'(bus_idle), 0);
    recs(1);
    chk("t5_idle11", 32'(bus_idle), 1);
    chk("t5_scnt", 32'(stuff_cnt), 32'(ST));

    // 6: reset mid-frame with sample_en high
    send(1'b0);
    send(1'b1);
    chk_bit("t6_b1", 1'b1, 1'b1);
    @(negedge clk);
    reset     = 1'b1;
    sample_en = 1'b1;
    data      = 1'b0;
    @(negedge clk);
    reset     = 1'b0;
    sample_en = 1'b0;
    data      = 1'b1;
    chk("t6_valid", 32'(bit_valid), 0);
    chk("t6_sof",   32'(sof), 0);
    chk("t6_out",   32'(bit_out), 0);
    chk("t6_err",   32'(stuff_err), 0);
    chk("t6_idle",  32'(bus_idle), 0);
    chk("t6_scnt",  32'(stuff_cnt), 0);
    chk("t6_ecnt",  32'(err_cnt), 0);
    send(1'b0);
    chk("t6_nosof", 32'(bit_valid), 0);
    recs(10);
    chk("t6_idle10", 32'(bus_idle), 0);
    recs(1);
    chk("t6_idle11", 32'(bus_idle), 1);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
